// File: rtl/neo_pbus_pkg.sv
// Shared constants, window-state encoding and bus encoders for the P-bus
// address driver.
package neo_pbus_pkg;

  localparam int          DEF_PERIOD    = 8;
  localparam int          DEF_C_PHASE   = 0;
  localparam int          DEF_S_PHASE   = 4;
  localparam logic [19:0] DEF_IDLE_PBUS = 20'h00000;

  localparam int PBUS_W = 20;
  localparam int C_W    = 20;
  localparam int S_W    = 16;

  // Per-channel strobe window: IDLE -> SETUP (strobe low) -> RISE (strobe
  // high, done) -> HOLD (bus still driven) -> IDLE.
  typedef logic [1:0] win_t;
  localparam win_t WIN_IDLE  = 2'd0;
  localparam win_t WIN_SETUP = 2'd1;
  localparam win_t WIN_RISE  = 2'd2;
  localparam win_t WIN_HOLD  = 2'd3;

  // The latch chip rotates on capture; pre-rotate so it recovers the
  // original C-ROM address.
  function automatic logic [19:0] enc_c(input logic [19:0] a);
    return {a[3:0], a[19:4]};
  endfunction

  // Fix addresses occupy the low 16 bits, rotated the same way.
  function automatic logic [19:0] enc_s(input logic [15:0] a);
    return {4'h0, a[3:0], a[15:4]};
  endfunction

endpackage

// File: rtl/neo_pbus_if.sv
// Request handshakes and P-bus outputs of the address driver.
//
// Handshake (both channels): a transfer happens on a rising CLK edge where
// valid and ready are both 1. The source holds addr stable while valid is 1
// and ready is 0; ready may depend combinationally on the holding register
// and the phase, but never on valid.
interface neo_pbus_if;
  import neo_pbus_pkg::*;

  logic              phase_rst;
  logic [C_W-1:0]    c_addr;
  logic              c_valid;
  logic              c_ready;
  logic [S_W-1:0]    s_addr;
  logic              s_valid;
  logic              s_ready;
  logic [PBUS_W-1:0] PBUS;
  logic              PCK1B;
  logic              PCK2B;
  logic              c_done;
  logic              s_done;

  // Address source side.
  modport master (
    output phase_rst, c_addr, c_valid, s_addr, s_valid,
    input  c_ready, s_ready, PBUS, PCK1B, PCK2B, c_done, s_done
  );

  // Driver side.
  modport slave (
    input  phase_rst, c_addr, c_valid, s_addr, s_valid,
    output c_ready, s_ready, PBUS, PCK1B, PCK2B, c_done, s_done
  );

endinterface

// File: rtl/neo_pbus_chan.sv
// One address channel: holding register, ready logic, strobe window counter
// and done pulse. The top decides what goes on the shared bus using the
// drive_nxt / val_nxt look-ahead outputs.
module neo_pbus_chan
  import neo_pbus_pkg::*;
#(
  parameter int W     = 20,
  parameter int PH_W  = 3,
  parameter int PHASE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PH_W-1:0] ph,
  input  logic            blocked,
  input  logic [W-1:0]    addr,
  input  logic            valid,
  output logic            ready,
  output logic            drive_nxt,
  output logic [W-1:0]    val_nxt,
  output logic            pck,
  output logic            done,
  output win_t            win
);

  localparam logic [PH_W-1:0] PH_L = PH_W'(PHASE);

  logic         full_q;
  logic         pend_q;
  logic [W-1:0] hold_q;
  logic [W-1:0] win_dat_q;
  win_t         win_q;
  logic         pck_q;
  logic         done_q;

  logic at_phase;
  logic want;
  logic launch;

  // A launch is wanted at our phase, or later if it was deferred because a
  // window was still in flight (only possible after a phase_rst).
  assign at_phase = (ph == PH_L);
  assign want     = full_q && (at_phase || pend_q);
  assign launch   = want && (win_q == WIN_IDLE) && !blocked;

  // A load and a consume in the same cycle keep the register full.
  assign ready = rst_n && (!full_q || launch);

  // Bus is driven in the three cycles after launch.
  assign drive_nxt = launch || (win_q == WIN_SETUP) || (win_q == WIN_RISE);
  assign val_nxt   = launch ? hold_q : win_dat_q;

  assign pck  = pck_q;
  assign done = done_q;
  assign win  = win_q;

  // Holding register, deferred-launch flag, window counter and strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q    <= 1'b0;
      pend_q    <= 1'b0;
      hold_q    <= '0;
      win_dat_q <= '0;
      win_q     <= WIN_IDLE;
      pck_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      if (valid && ready) begin
        hold_q <= addr;
        full_q <= 1'b1;
      end else if (launch) begin
        full_q <= 1'b0;
      end

      pend_q <= want && !launch;

      if (launch) begin
        win_dat_q <= hold_q;
      end

      case (win_q)
        WIN_IDLE:  win_q <= launch ? WIN_SETUP : WIN_IDLE;
        WIN_SETUP: win_q <= WIN_RISE;
        WIN_RISE:  win_q <= WIN_HOLD;
        default:   win_q <= WIN_IDLE;
      endcase

      pck_q  <= !launch;
      done_q <= (win_q == WIN_SETUP);
    end
  end

endmodule

// File: rtl/neo_pbus_drv.sv
// P-bus address driver: phase counter, two launch channels and the
// registered PBUS multiplexer.
module neo_pbus_drv
  import neo_pbus_pkg::*;
#(
  parameter int          PERIOD    = DEF_PERIOD,
  parameter int          C_PHASE   = DEF_C_PHASE,
  parameter int          S_PHASE   = DEF_S_PHASE,
  parameter logic [19:0] IDLE_PBUS = DEF_IDLE_PBUS
) (
  input  logic       CLK,
  input  logic       nRESET,
  neo_pbus_if.slave  bus,
  output logic [7:0] dbg_ph,
  output win_t       dbg_c_win,
  output win_t       dbg_s_win
);

  // PERIOD >= 6 and slot spacing >= 3 are assumed by the window timing.
  localparam int PH_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);

  logic [PH_W-1:0]   ph_q;
  logic [PBUS_W-1:0] pbus_q;

  logic           c_drive_nxt;
  logic [C_W-1:0] c_val_nxt;
  logic           s_drive_nxt;
  logic [S_W-1:0] s_val_nxt;

  // Phase counter; phase_rst realigns to 0 on the next cycle.
  always_ff @(posedge CLK) begin
    if (!nRESET || bus.phase_rst) begin
      ph_q <= '0;
    end else if (ph_q == PH_LAST) begin
      ph_q <= '0;
    end else begin
      ph_q <= ph_q + 1'b1;
    end
  end

  neo_pbus_chan #(
    .W     (C_W),
    .PH_W  (PH_W),
    .PHASE (C_PHASE)
  ) u_c (
    .clk       (CLK),
    .rst_n     (nRESET),
    .ph        (ph_q),
    .blocked   (1'b0),
    .addr      (bus.c_addr),
    .valid     (bus.c_valid),
    .ready     (bus.c_ready),
    .drive_nxt (c_drive_nxt),
    .val_nxt   (c_val_nxt),
    .pck       (bus.PCK1B),
    .done      (bus.c_done),
    .win       (dbg_c_win)
  );

  // C owns the bus, so an S launch waits while C will drive next cycle.
  neo_pbus_chan #(
    .W     (S_W),
    .PH_W  (PH_W),
    .PHASE (S_PHASE)
  ) u_s (
    .clk       (CLK),
    .rst_n     (nRESET),
    .ph        (ph_q),
    .blocked   (c_drive_nxt),
    .addr      (bus.s_addr),
    .valid     (bus.s_valid),
    .ready     (bus.s_ready),
    .drive_nxt (s_drive_nxt),
    .val_nxt   (s_val_nxt),
    .pck       (bus.PCK2B),
    .done      (bus.s_done),
    .win       (dbg_s_win)
  );

  // Registered bus mux, C first, idle value otherwise.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      pbus_q <= IDLE_PBUS;
    end else if (c_drive_nxt) begin
      pbus_q <= enc_c(c_val_nxt);
    end else if (s_drive_nxt) begin
      pbus_q <= enc_s(s_val_nxt);
    end else begin
      pbus_q <= IDLE_PBUS;
    end
  end

  assign bus.PBUS = pbus_q;
  assign dbg_ph   = 8'(ph_q);

endmodule

// File: doc/neo_pbus_drv.md
Name: neo_pbus_drv

Overview:
- Driving end of the P-bus address path.
- Accepts sprite C-ROM tile addresses (20-bit) and fix S-ROM addresses (16-bit) through valid/ready handshakes.
- Time-multiplexes them onto the shared 20-bit PBUS in fixed slots of a repeating phase sequence, and generates the PCK1B/PCK2B latch strobes.
- The receiving latch chip recovers the original addresses from the bus on the strobe rising edges; this block applies the matching bit rotation before driving.

Parameters:
- PERIOD, 8: phase counter length in CLK cycles. Must be ≥ 6.
- C_PHASE, 0: phase at which a pending C address is launched.
- S_PHASE, 4: phase at which a pending S address is launched. Slot windows must not overlap: |C_PHASE−S_PHASE| ≥ 3 mod PERIOD.
- IDLE_PBUS, 20'h00000: value driven on PBUS outside active windows.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- nRESET  in  1  synchronous, active-low reset.
- phase_rst  in  1  realign; phase counter is 0 on the next cycle.
- c_addr  in  20  sprite C-ROM address.
- c_valid  in  1  c_addr valid.
- c_ready  out  1  C holding register can accept.
- s_addr  in  16  fix S-ROM address.
- s_valid  in  1  s_addr valid.
- s_ready  out  1  S holding register can accept.
- PBUS  out  20  multiplexed address bus.
- PCK1B  out  1  C latch strobe; receiver samples on its rising edge.
- PCK2B  out  1  S latch strobe; receiver samples on its rising edge.
- c_done  out  1  one-cycle pulse in the cycle PCK1B rises.
- s_done  out  1  one-cycle pulse in the cycle PCK2B rises.

Behaviour:
- Reset values (nRESET low at an edge): ph=0; both holding registers empty; PBUS=IDLE_PBUS; PCK1B=PCK2B=1; c_done=s_done=0. c_ready and s_ready are 0 while nRESET is low and 1 in the first cycle after release.
- Phase counter ph: 0..PERIOD−1, increments every cycle, wraps to 0. phase_rst has priority and forces ph=0 next cycle.
- Holding registers, one per channel:
  - Loads on valid&&ready.
  - ready = !full || consume_this_cycle, so a load and a consume in the same cycle keep the register full with the new data.
  - consume_C = (ph==C_PHASE) && C_full; consume_S is the same with S_PHASE.
  - A request accepted in the cycle ph==X_PHASE is not consumed in that cycle; it goes at the next occurrence.
- Encoding, all outputs registered:
  - C slot: PBUS = {c[3:0], c[19:4]}.
  - S slot: PBUS = {4'h0, s[3:0], s[15:4]}.
- C window, on consume_C at cycle t:
  - PBUS holds the encoded C value during cycles t+1..t+3.
  - PCK1B=0 at t+1 and 1 at t+2, giving one rising edge with one cycle of setup and one of hold.
  - c_done=1 at t+2.
- S window: identical, using PCK2B and s_done.
- Idle slots (register empty at launch phase): no strobe low pulse; PBUS returns to IDLE_PBUS after any prior window ends.
- phase_rst mid-window: an already-launched window completes on its cycle schedule, independent of ph (separate 2-bit window counter per channel). Holding registers are untouched.
- A new launch cannot collide with an in-flight window, because slot spacing ≥ 3 is enforced by parameter. Exception: a phase_rst during a window may retrigger the same channel's phase early. In that case the launch is deferred until that channel's window counter is idle, then it proceeds.
- Reset mid-window: the window is aborted immediately, and PCK returns to 1 without a done pulse.
  - The resulting 0→1 on PCK is an edge. Receivers are also held in reset, so this is accepted.
- PBUS arbitration: if windows overlap after a phase_rst, the C window owns PBUS. The S launch is deferred as above.

Decomposition:
- Package neo_pbus_pkg:
  - Default PERIOD, C_PHASE, S_PHASE, IDLE_PBUS constants.
  - Functions enc_c(20→20) and enc_s(16→20).
  - Typedef for the 2-bit window counter state (IDLE, SETUP, RISE, HOLD).
- Sub-module neo_pbus_chan, instantiated twice:
  - Parameterised on address width and launch phase.
  - Contains the holding register, ready logic, window counter, and strobe/done generation.
- Top level owns the phase counter and the PBUS mux.

Test Plan:
- Reset release, no requests, 3 periods → PBUS=20'h00000 throughout, PCK1B=PCK2B=1, c_ready=s_ready=1.
- c_addr=20'hABCDE accepted at ph=6 → PBUS=20'hEABCD at ph 1..3, PCK1B low at ph=1, rising at ph=2, c_done at ph=2.
- s_addr=16'h1234 accepted at ph=2 → PBUS=20'h04123 at ph 5..7, PCK2B rising at ph=6.
- Back-to-back C requests 20'h00001, 20'hFFFFF with c_valid held high → second accepted in the same cycle the first is consumed. Bus shows 20'h10000 then 20'hFFFFF in consecutive periods; no lost or duplicated strobes.
- phase_rst asserted at ph=1 during a C window → PCK1B still rises one cycle later with PBUS stable. Next C launch occurs at the realigned ph=0.
- nRESET low while PCK2B=0 → next cycle PCK2B=1, s_done=0, holding registers empty, PBUS=IDLE_PBUS.
